// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle trail compositor.
//   dir_t       : bike heading encoding as delivered on head_dir
//   state_t     : round state (running / round over)
//   C_*         : default colour-enum values for empty arena, transparent
//                 sprite and crashed-player sprite
//   probe_point : head position + heading -> collision probe point,
//                 all arithmetic modulo 2^COORD_W
package tron_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  localparam logic [3:0] C_BG_COLOR    = 4'h0;
  localparam logic [3:0] C_TRANSP      = 4'hF;
  localparam logic [3:0] C_CRASH_COLOR = 4'hC;

  // Returns {probe_x, probe_y}. Subtraction wraps, so a probe that would
  // fall left of / above the arena lands at a large coordinate instead.
  function automatic logic [2*COORD_W-1:0] probe_point(
    input logic [COORD_W-1:0] hx,
    input logic [COORD_W-1:0] hy,
    input dir_t               dir,
    input logic [COORD_W-1:0] ahead,
    input logic [COORD_W-1:0] side
  );
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    px = hx;
    py = hy;
    case (dir)
      DIR_DOWN:  begin px = hx + side;  py = hy + ahead; end
      DIR_UP:    begin px = hx + side;  py = hy - ahead; end
      DIR_RIGHT: begin px = hx + ahead; py = hy + side;  end
      DIR_LEFT:  begin px = hx - ahead; py = hy + side;  end
      default:   begin px = hx;         py = hy;         end
    endcase
    return {px, py};
  endfunction

endpackage

// File: rtl/trail_compositor_if.sv
// Frame-RAM read port bundle.
//   fb_rd_addr : read address, driven combinationally by the compositor
//   fb_rd_data : read data, returned by the RAM one clock after the address
// master = compositor side, slave = RAM side.
interface trail_compositor_if #(
  parameter int ADDR_W = 19,
  parameter int WORD_W = 16
);
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [WORD_W-1:0] fb_rd_data;

  modport master (output fb_rd_addr, input  fb_rd_data);
  modport slave  (input  fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/trail_compositor_head_probe.sv
// Per-player collision probe.
// Computes the probe point from the live head position/heading, captures it
// at each frame boundary so it is stable for the whole frame, and flags a hit
// when the stage-2 scan coordinate lands on the probe over a non-empty trail.
//   Clk, Reset         : clock, synchronous active-high reset
//   i_frame_edge       : one-cycle frame boundary strobe
//   i_head_x/i_head_y  : head position
//   i_dir              : heading
//   i_s2_active/x/y    : stage-2 scan position and visibility
//   i_s2_trail         : stage-2 trail pixel (before sprite overlay)
//   o_hit              : probe hit in this cycle
module head_probe
  import tron_pkg::*;
#(
  parameter int                  H_RES       = 640,
  parameter int                  V_RES       = 480,
  parameter int                  PIX_BITS    = 4,
  parameter int                  PROBE_AHEAD = 16,
  parameter int                  PROBE_SIDE  = 3,
  parameter logic [PIX_BITS-1:0] BG_COLOR    = PIX_BITS'(C_BG_COLOR)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_frame_edge,
  input  logic [COORD_W-1:0] i_head_x,
  input  logic [COORD_W-1:0] i_head_y,
  input  dir_t               i_dir,
  input  logic               i_s2_active,
  input  logic [COORD_W-1:0] i_s2_x,
  input  logic [COORD_W-1:0] i_s2_y,
  input  logic [PIX_BITS-1:0] i_s2_trail,
  output logic               o_hit
);

  logic [COORD_W-1:0] w_probe_x;
  logic [COORD_W-1:0] w_probe_y;
  logic [COORD_W-1:0] r_probe_x;
  logic [COORD_W-1:0] r_probe_y;
  logic               r_probe_valid;
  logic               w_on_screen;

  always_comb begin
    {w_probe_x, w_probe_y} = probe_point(i_head_x, i_head_y, i_dir,
                                         COORD_W'(PROBE_AHEAD), COORD_W'(PROBE_SIDE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_probe_x     <= '0;
      r_probe_y     <= '0;
      r_probe_valid <= 1'b0;
    end else if (i_frame_edge) begin
      r_probe_x     <= w_probe_x;
      r_probe_y     <= w_probe_y;
      r_probe_valid <= 1'b1;
    end
  end

  // A wrapped probe can never equal an active coordinate anyway; the explicit
  // bound keeps off-screen probes inert even if the active gate changes.
  assign w_on_screen = (32'(r_probe_x) < 32'(H_RES)) && (32'(r_probe_y) < 32'(V_RES));

  assign o_hit = r_probe_valid && w_on_screen && i_s2_active &&
                 (i_s2_x == r_probe_x) && (i_s2_y == r_probe_y) &&
                 (i_s2_trail != BG_COLOR);

endmodule

// File: rtl/trail_compositor.sv
// Trail/sprite pixel compositor and per-player collision detector.
// Fetches packed trail pixels from the frame RAM, overlays the bike sprite,
// accumulates per-player probe hits over a frame, publishes them at each
// frame boundary and holds the round in ST_OVER once anyone has crashed.
//   Clk, Reset        : clock, synchronous active-high reset
//   frame_clk         : frame level; rising edge marks the frame boundary
//   restart           : one-cycle pulse starting a new round
//   DrawX, DrawY      : scan position
//   sprite_pix/id     : bike sprite pixel at the scan position and its owner
//   head_x/y/dir      : packed per-player head positions and headings
//   fb                : frame-RAM read port (address out, data one cycle later)
//   color_enum        : composited pixel, 2 cycles after DrawX/DrawY
//   hit_flags         : per-player crash flags of the last published frame
//   hit_valid         : one-cycle pulse when hit_flags is published
//   round_over        : high while in ST_OVER
//
// state   | meaning
// ST_RUN  | round in progress; hits accumulate and publish every frame
// ST_OVER | a published frame had crashes; flags frozen until restart
module trail_compositor
  import tron_pkg::*;
#(
  parameter int                  NUM_PLAYERS  = 2,
  parameter int                  H_RES        = 640,
  parameter int                  V_RES        = 480,
  parameter int                  PIX_BITS     = 4,
  parameter int                  WORD_W       = 16,
  parameter int                  PIX_PER_WORD = 2,
  parameter int                  ADDR_W       = 19,
  parameter int                  PROBE_AHEAD  = 16,
  parameter int                  PROBE_SIDE   = 3,
  parameter logic [PIX_BITS-1:0] BG_COLOR     = PIX_BITS'(C_BG_COLOR),
  parameter logic [PIX_BITS-1:0] TRANSP       = PIX_BITS'(C_TRANSP),
  parameter logic [PIX_BITS-1:0] CRASH_COLOR  = PIX_BITS'(C_CRASH_COLOR),
  localparam int                 SID_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic                           restart,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [PIX_BITS-1:0]            sprite_pix,
  input  logic [SID_W-1:0]               sprite_id,
  input  logic [NUM_PLAYERS*COORD_W-1:0] head_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] head_y,
  input  logic [NUM_PLAYERS*2-1:0]       head_dir,
  trail_compositor_if.master             fb,
  output logic [PIX_BITS-1:0]            color_enum,
  output logic [NUM_PLAYERS-1:0]         hit_flags,
  output logic                           hit_valid,
  output logic                           round_over
);

  localparam int WORDS_PER_LINE = H_RES / PIX_PER_WORD;
  localparam int LANE_W         = WORD_W / PIX_PER_WORD;
  localparam int LANE_SEL_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  // stage 1: aligned with the RAM read data
  logic [LANE_SEL_W-1:0] r1_lane;
  logic [PIX_BITS-1:0]   r1_spr;
  logic [SID_W-1:0]      r1_id;
  logic [COORD_W-1:0]    r1_x;
  logic [COORD_W-1:0]    r1_y;
  logic                  r1_active;
  // stage 2: aligned with color_enum
  logic [COORD_W-1:0]    r2_x;
  logic [COORD_W-1:0]    r2_y;
  logic                  r2_active;
  logic [PIX_BITS-1:0]   r2_trail;
  logic [PIX_BITS-1:0]   r_color_enum;

  logic [LANE_SEL_W-1:0] w_lane;
  logic                  w_active;
  logic [PIX_BITS-1:0]   w_trail;
  logic                  w_owner_crashed;
  logic [PIX_BITS-1:0]   w_color_next;

  logic                   r_fclk_d;
  logic                   w_frame_edge;
  logic [NUM_PLAYERS-1:0] w_hit;
  logic [NUM_PLAYERS-1:0] r_hit_acc;
  logic [NUM_PLAYERS-1:0] r_hit_flags;
  logic                   r_hit_valid;
  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_round_over;

  assign fb.fb_rd_addr = ADDR_W'(32'(DrawY) * 32'(WORDS_PER_LINE) + 32'(DrawX) / 32'(PIX_PER_WORD));
  assign w_lane        = LANE_SEL_W'(32'(DrawX) % 32'(PIX_PER_WORD));
  assign w_active      = (32'(DrawX) < 32'(H_RES)) && (32'(DrawY) < 32'(V_RES));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r1_lane   <= '0;
      r1_spr    <= TRANSP;
      r1_id     <= '0;
      r1_x      <= '0;
      r1_y      <= '0;
      r1_active <= 1'b0;
    end else begin
      r1_lane   <= w_lane;
      r1_spr    <= sprite_pix;
      r1_id     <= sprite_id;
      r1_x      <= DrawX;
      r1_y      <= DrawY;
      r1_active <= w_active;
    end
  end

  always_comb begin
    w_trail = BG_COLOR;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (r1_lane == LANE_SEL_W'(k)) w_trail = fb.fb_rd_data[k*LANE_W +: PIX_BITS];
    end
  end

  always_comb begin
    w_owner_crashed = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (r1_id == SID_W'(p)) w_owner_crashed = r_hit_flags[p];
    end
  end

  always_comb begin
    w_color_next = BG_COLOR;
    if (r1_active) begin
      if (r1_spr != TRANSP) begin
        w_color_next = ((r_state == ST_OVER) && w_owner_crashed) ? CRASH_COLOR : r1_spr;
      end else begin
        w_color_next = w_trail;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r2_x         <= '0;
      r2_y         <= '0;
      r2_active    <= 1'b0;
      r2_trail     <= BG_COLOR;
      r_color_enum <= BG_COLOR;
    end else begin
      r2_x         <= r1_x;
      r2_y         <= r1_y;
      r2_active    <= r1_active;
      r2_trail     <= w_trail;
      r_color_enum <= w_color_next;
    end
  end

  assign color_enum = r_color_enum;

  always_ff @(posedge Clk) begin
    if (Reset) r_fclk_d <= 1'b0;
    else       r_fclk_d <= frame_clk;
  end

  assign w_frame_edge = frame_clk && !r_fclk_d;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_probe
    head_probe #(
      .H_RES       (H_RES),
      .V_RES       (V_RES),
      .PIX_BITS    (PIX_BITS),
      .PROBE_AHEAD (PROBE_AHEAD),
      .PROBE_SIDE  (PROBE_SIDE),
      .BG_COLOR    (BG_COLOR)
    ) u_head_probe (
      .Clk          (Clk),
      .Reset        (Reset),
      .i_frame_edge (w_frame_edge),
      .i_head_x     (head_x[i*COORD_W +: COORD_W]),
      .i_head_y     (head_y[i*COORD_W +: COORD_W]),
      .i_dir        (dir_t'(head_dir[i*2 +: 2])),
      .i_s2_active  (r2_active),
      .i_s2_x       (r2_x),
      .i_s2_y       (r2_y),
      .i_s2_trail   (r2_trail),
      .o_hit        (w_hit[i])
    );
  end

  // A hit seen in the boundary cycle seeds the new frame's accumulator.
  // restart takes priority over a coincident boundary.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hit_acc   <= '0;
      r_hit_flags <= '0;
      r_hit_valid <= 1'b0;
    end else begin
      r_hit_valid <= 1'b0;
      if (restart) begin
        r_hit_acc <= '0;
        if (r_state == ST_OVER) r_hit_flags <= '0;
      end else if (r_state == ST_RUN) begin
        if (w_frame_edge) begin
          r_hit_flags <= r_hit_acc;
          r_hit_valid <= 1'b1;
          r_hit_acc   <= w_hit;
        end else begin
          r_hit_acc   <= r_hit_acc | w_hit;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_round_over = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!restart && w_frame_edge && (|r_hit_acc)) w_state_next = ST_OVER;
      end
      ST_OVER: begin
        w_round_over = 1'b1;
        if (restart) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign hit_flags  = r_hit_flags;
  assign hit_valid  = r_hit_valid;
  assign round_over = w_round_over;

endmodule

// File: tb/tb_trail_compositor.sv
module tb_trail_compositor;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        restart;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  sprite_pix;
  logic [0:0]  sprite_id;
  logic [19:0] head_x;
  logic [19:0] head_y;
  logic [3:0]  head_dir;
  logic [3:0]  color_enum;
  logic [1:0]  hit_flags;
  logic        hit_valid;
  logic        round_over;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [int];

  trail_compositor_if #(.ADDR_W(19), .WORD_W(16)) fb_if ();

  trail_compositor dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .restart    (restart),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .sprite_pix (sprite_pix),
    .sprite_id  (sprite_id),
    .head_x     (head_x),
    .head_y     (head_y),
    .head_dir   (head_dir),
    .fb         (fb_if),
    .color_enum (color_enum),
    .hit_flags  (hit_flags),
    .hit_valid  (hit_valid),
    .round_over (round_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // frame RAM: one-cycle synchronous read, unwritten words read as empty arena
  always @(posedge Clk) begin
    fb_if.fb_rd_data <= mem.exists(int'(fb_if.fb_rd_addr)) ? mem[int'(fb_if.fb_rd_addr)] : 16'h0000;
  end

  // ---------------- reference model ----------------
  function automatic int word_addr(int x, int y);
    return y * 320 + x / 2;
  endfunction

  function automatic logic [3:0] trail_at(int x, int y);
    int a;
    logic [15:0] w;
    a = word_addr(x, y);
    w = mem.exists(a) ? mem[a] : 16'h0000;
    return 4'((w >> ((x % 2) * 8)) & 16'h000F);
  endfunction

  function automatic logic [3:0] exp_color(int x, int y, logic [3:0] spr, int id, bit over, logic [1:0] flags);
    if (x >= 640 || y >= 480) return 4'h0;
    if (spr != 4'hF) return (over && flags[id]) ? 4'hC : spr;
    return trail_at(x, y);
  endfunction

  function automatic void probe_of(int hx, int hy, int dir, output int px, output int py);
    case (dir)
      0:       begin px = (hx + 3) & 1023;  py = (hy + 16) & 1023; end
      1:       begin px = (hx + 3) & 1023;  py = (hy - 16) & 1023; end
      2:       begin px = (hx + 16) & 1023; py = (hy + 3) & 1023;  end
      default: begin px = (hx - 16) & 1023; py = (hy + 3) & 1023;  end
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(int x, int y, logic [3:0] spr, int id);
    DrawX      = 10'(x);
    DrawY      = 10'(y);
    sprite_pix = spr;
    sprite_id  = 1'(id);
  endtask

  task automatic idle();
    drive(700, 0, 4'hF, 0);
  endtask

  task automatic set_pix(int x, int y, logic [3:0] v);
    int a;
    logic [15:0] w;
    a = word_addr(x, y);
    w = mem.exists(a) ? mem[a] : 16'h0000;
    if (x % 2 == 0) w[3:0] = v;
    else            w[11:8] = v;
    mem[a] = w;
  endtask

  task automatic set_heads(int x0, int y0, int d0, int x1, int y1, int d1);
    head_x   = {10'(x1), 10'(x0)};
    head_y   = {10'(y1), 10'(y0)};
    head_dir = {2'(d1), 2'(d0)};
  endtask

  task automatic pulse_frame(output logic [1:0] f, output logic v, output logic o, output logic v_after);
    frame_clk = 1'b1;
    tick();
    f = hit_flags;
    v = hit_valid;
    o = round_over;
    frame_clk = 1'b0;
    tick();
    v_after = hit_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; restart = 1'b0;
    idle();
    set_heads(300, 300, 2, 300, 400, 2);
    repeat (3) tick();
    total++; if (color_enum !== 4'h0) begin bad++; $display("FAIL reset_color got %h want 0", color_enum); end
    total++; if (hit_flags !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", hit_flags); end
    total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", hit_valid); end
    total++; if (round_over !== 1'b0) begin bad++; $display("FAIL reset_over got %b want 0", round_over); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_compose_fixed();
    mem[0] = 16'h0305;
    drive(0, 0, 4'hF, 0); tick();
    total++; if (color_enum !== 4'h0) begin bad++; $display("FAIL latency_early got %h want 0", color_enum); end
    drive(1, 0, 4'hF, 0); tick();
    total++; if (color_enum !== 4'h5) begin bad++; $display("FAIL lane0 got %h want 5", color_enum); end
    drive(0, 0, 4'h2, 0); tick();
    total++; if (color_enum !== 4'h3) begin bad++; $display("FAIL lane1 got %h want 3", color_enum); end
    drive(640, 0, 4'h2, 0); tick();
    total++; if (color_enum !== 4'h2) begin bad++; $display("FAIL sprite_over got %h want 2", color_enum); end
    idle(); tick();
    total++; if (color_enum !== 4'h0) begin bad++; $display("FAIL offscreen_x got %h want 0", color_enum); end
  endtask

  task automatic test_compose_random();
    int xs[40];
    int ys[40];
    logic [3:0] sp[40];
    int ids[40];
    logic [3:0] ex[40];
    for (int i = 0; i < 40; i++) begin
      xs[i]  = int'($urandom_range(0, 700));
      ys[i]  = int'($urandom_range(0, 500));
      sp[i]  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      ids[i] = int'($urandom_range(0, 1));
      if (xs[i] < 640 && ys[i] < 480) mem[word_addr(xs[i], ys[i])] = 16'($urandom);
    end
    for (int i = 0; i < 40; i++) ex[i] = exp_color(xs[i], ys[i], sp[i], ids[i], 1'b0, 2'b00);
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) drive(xs[i], ys[i], sp[i], ids[i]);
      else        idle();
      tick();
      if (i >= 1) begin
        total++;
        if (color_enum !== ex[i-1]) begin
          bad++;
          $display("FAIL rand_pix%0d (%0d,%0d) got %h want %h", i-1, xs[i-1], ys[i-1], color_enum, ex[i-1]);
        end
      end
    end
    idle(); tick();
  endtask

  task automatic test_wrap_no_hit();
    logic [1:0] f; logic v, o, va;
    set_heads(300, 200, 2, 5, 50, 3);   // P0 probe (316,203), P1 probe (1013,53)
    set_pix(316, 203, 4'h0);
    mem[word_addr(1013, 53)] = 16'h0909;
    for (int x = 0; x <= 20; x++) set_pix(x, 53, 4'h9);
    pulse_frame(f, v, o, va);
    for (int fr = 0; fr < 3; fr++) begin
      drive(1013, 53, 4'hF, 0); tick();
      for (int x = 0; x <= 20; x++) begin drive(x, 53, 4'hF, 1); tick(); end
      drive(316, 203, 4'hF, 0); tick();
      idle(); repeat (3) tick();
      pulse_frame(f, v, o, va);
      total++; if (f !== 2'b00) begin bad++; $display("FAIL wrap_flags frame%0d got %b want 00", fr, f); end
      total++; if (v !== 1'b1) begin bad++; $display("FAIL wrap_valid frame%0d got %b want 1", fr, v); end
    end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL wrap_over got %b want 0", o); end
  endtask

  task automatic test_crash();
    logic [1:0] f; logic v, o, va;
    set_heads(100, 100, 0, 5, 50, 3);
    set_pix(103, 116, 4'h5);
    pulse_frame(f, v, o, va);
    drive(103, 116, 4'hF, 0); tick();
    idle(); repeat (3) tick();
    pulse_frame(f, v, o, va);
    total++; if (f !== 2'b01) begin bad++; $display("FAIL crash_flags got %b want 01", f); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL crash_valid got %b want 1", v); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL crash_over got %b want 1", o); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL crash_valid_width got %b want 0", va); end
  endtask

  task automatic test_over();
    logic [1:0] f; logic v, o, va;
    drive(103, 116, 4'h7, 0); tick();
    drive(103, 116, 4'h7, 1); tick();
    total++; if (color_enum !== 4'hC) begin bad++; $display("FAIL over_crash_sprite got %h want c", color_enum); end
    drive(103, 116, 4'hF, 0); tick();
    total++; if (color_enum !== 4'h7) begin bad++; $display("FAIL over_live_sprite got %h want 7", color_enum); end
    idle(); tick();
    total++; if (color_enum !== 4'h5) begin bad++; $display("FAIL over_trail got %h want 5", color_enum); end
    repeat (3) tick();
    pulse_frame(f, v, o, va);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL over_no_publish got %b want 0", v); end
    total++; if (f !== 2'b01) begin bad++; $display("FAIL over_frozen got %b want 01", f); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL over_stays got %b want 1", o); end
  endtask

  task automatic test_restart_edge();
    restart = 1'b1; frame_clk = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (round_over !== 1'b0) begin bad++; $display("FAIL rst_edge_over got %b want 0", round_over); end
    total++; if (hit_flags !== 2'b00) begin bad++; $display("FAIL rst_edge_flags got %b want 00", hit_flags); end
    total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL rst_edge_valid got %b want 0", hit_valid); end
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic test_edge_cycle_hit();
    logic [1:0] f; logic v, o, va;
    drive(103, 116, 4'hF, 0); tick();
    idle(); tick();
    frame_clk = 1'b1;             // stage-2 hit lands in this boundary cycle
    tick();
    total++; if (hit_valid !== 1'b1) begin bad++; $display("FAIL edgehit_valid got %b want 1", hit_valid); end
    total++; if (hit_flags !== 2'b00) begin bad++; $display("FAIL edgehit_not_now got %b want 00", hit_flags); end
    frame_clk = 1'b0;
    repeat (3) tick();
    pulse_frame(f, v, o, va);
    total++; if (f !== 2'b01) begin bad++; $display("FAIL edgehit_next got %b want 01", f); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL edgehit_over got %b want 1", o); end
    restart = 1'b1; tick(); restart = 1'b0;
    total++; if (round_over !== 1'b0 || hit_flags !== 2'b00) begin
      bad++; $display("FAIL restart_over got over=%b flags=%b want 0/00", round_over, hit_flags);
    end
  endtask

  task automatic test_restart_in_run();
    logic [1:0] f; logic v, o, va;
    drive(103, 116, 4'hF, 0); tick();
    idle(); repeat (3) tick();
    restart = 1'b1; tick(); restart = 1'b0;
    tick();
    pulse_frame(f, v, o, va);
    total++; if (f !== 2'b00 || v !== 1'b1 || o !== 1'b0) begin
      bad++; $display("FAIL run_restart got flags=%b valid=%b over=%b want 00/1/0", f, v, o);
    end
  endtask

  task automatic test_random_collisions();
    logic [1:0] f; logic v, o, va;
    int hx[2], hy[2], hd[2], px[2], py[2];
    int sx[8], sy[8];
    logic [1:0] expf;
    for (int it = 0; it < 8; it++) begin
      for (int p = 0; p < 2; p++) begin
        hx[p] = int'($urandom_range(0, 639));
        hy[p] = int'($urandom_range(0, 479));
        hd[p] = int'($urandom_range(0, 3));
        probe_of(hx[p], hy[p], hd[p], px[p], py[p]);
      end
      set_heads(hx[0], hy[0], hd[0], hx[1], hy[1], hd[1]);
      pulse_frame(f, v, o, va);
      total++; if (f !== 2'b00 || o !== 1'b0) begin
        bad++; $display("FAIL rcol%0d_quiet got flags=%b over=%b want 00/0", it, f, o);
      end
      for (int p = 0; p < 2; p++)
        if (px[p] < 640 && py[p] < 480)
          set_pix(px[p], py[p], ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 14)) : 4'h0);
      sx[0] = px[0]; sy[0] = py[0];
      sx[1] = px[1]; sy[1] = py[1];
      for (int s = 2; s < 8; s++) begin
        sx[s] = int'($urandom_range(0, 639));
        sy[s] = int'($urandom_range(0, 479));
      end
      expf = 2'b00;
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < 8; s++)
          if (sx[s] == px[p] && sy[s] == py[p] && sx[s] < 640 && sy[s] < 480 && trail_at(sx[s], sy[s]) != 4'h0)
            expf[p] = 1'b1;
      for (int s = 0; s < 8; s++) begin
        drive(sx[s], sy[s], 4'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        tick();
      end
      idle(); repeat (3) tick();
      pulse_frame(f, v, o, va);
      total++; if (f !== expf || v !== 1'b1 || o !== (|expf)) begin
        bad++; $display("FAIL rcol%0d got flags=%b valid=%b over=%b want %b/1/%b", it, f, v, o, expf, |expf);
      end
      if (o === 1'b1) begin restart = 1'b1; tick(); restart = 1'b0; tick(); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_compose_fixed();
    test_compose_random();
    test_wrap_no_hit();
    test_crash();
    test_over();
    test_restart_edge();
    test_edge_cycle_hit();
    test_restart_in_run();
    test_random_collisions();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
